serial_eq_ctrl: RTL and testbench

- Sequential controller that compares two WIDTH-bit operands for equality by time-sharing a single igual_2b2b 2-bit-equality instance.
- Captures both operands on a start handshake and steps through them one 2-bit slice per cycle, LSB slice first.
- Terminates early on the first mismatching slice.
- Reports equality, the index of the first differing slice, and a one-cycle done pulse; supports a synchronous abort.

---
 rtl/serial_eq_ctrl.sv | 114 +++++++++++
 tb/tb_serial_eq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_eq_ctrl.sv
// Sequential equality checker: walks two WIDTH-bit operands one 2-bit slice per
// cycle through a single shared igual_2b2b comparator, stopping at the first mismatch.

module igual_2b2b (
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic eq
);
    // {A,B} and {C,D} are the two 2-bit values being compared
    assign eq = (A ~^ C) & (B ~^ D);
endmodule

module serial_eq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IW    = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [IW-1:0]    diff_slice
);
    localparam int unsigned NS = WIDTH / 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [IW-1:0]    idx;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             slice_eq;

    // Select the current 2-bit slice of each captured operand
    assign slice_a = 2'(ra >> {idx, 1'b0});
    assign slice_b = 2'(rb >> {idx, 1'b0});

    igual_2b2b u_cmp (
        .A  (slice_a[1]),
        .B  (slice_a[0]),
        .C  (slice_b[1]),
        .D  (slice_b[0]),
        .eq (slice_eq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ra         <= '0;
            rb         <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            equal      <= 1'b0;
            diff_slice <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ra         <= a;
                        rb         <= b;
                        idx        <= '0;
                        equal      <= 1'b0;
                        diff_slice <= '0;
                        busy       <= 1'b1;
                        state      <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    // Abort wins over the slice result of this cycle
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (!slice_eq) begin
                        equal      <= 1'b0;
                        diff_slice <= idx;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else if (idx == LAST_IDX) begin
                        equal      <= 1'b1;
                        diff_slice <= '0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_eq_ctrl.sv
// Bench for serial_eq_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.

module tb_serial_eq_ctrl;
    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       busy;
    logic       done;
    logic       equal;
    logic [1:0] diff_slice;

    int n_vec = 0;
    int n_err = 0;

    serial_eq_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .equal      (equal),
        .diff_slice (diff_slice)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Index of first differing 2-bit slice, or NS-1 when operands are equal
    function automatic int first_diff(input logic [7:0] x, input logic [7:0] y);
        for (int s = 0; s < NS; s++)
            if (((x >> (2 * s)) & 8'h3) != ((y >> (2 * s)) & 8'h3)) return s;
        return NS - 1;
    endfunction

    // Transaction model: on accept, result is known up front; only timing is counted down
    int         m_phase = 0;
    int         m_rem = 0;
    logic       m_fin_eq = 1'b0;
    logic [1:0] m_fin_diff = 2'd0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_equal = 1'b0;
    logic [1:0] m_diff = 2'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_busy = 0; m_done = 0; m_equal = 0; m_diff = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_rem      = first_diff(a, b) + 1;
                    m_fin_eq   = (a == b);
                    m_fin_diff = (a == b) ? 2'd0 : 2'(first_diff(a, b));
                    m_equal    = 0;
                    m_diff     = 0;
                    m_busy     = 1;
                    m_phase    = 1;
                end
                1: if (abort) begin
                    m_busy  = 0;
                    m_phase = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done  = 1;
                        m_equal = m_fin_eq;
                        m_diff  = m_fin_diff;
                        m_phase = 2;
                    end
                end
                default: begin
                    m_done  = 0;
                    m_busy  = 0;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_busy));
        check("done", int'(done), int'(m_done));
        check("equal", int'(equal), int'(m_equal));
        check("diff_slice", int'(diff_slice), int'(m_diff));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one edge (E0); returns just after E0
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(inout int lat);
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int lat;

    initial begin
        rst = 1'b1;
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset equal", int'(equal), 0);
        check("reset diff", int'(diff_slice), 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Equal operands: full NS compare cycles
        start_op(8'hA5, 8'hA5);
        check("eq busy", int'(busy), 1);
        lat = 0; wait_done(lat);
        check("eq latency", lat, 4);
        check("eq equal", int'(equal), 1);
        check("eq diff", int'(diff_slice), 0);
        tick();
        check("eq busy after", int'(busy), 0);
        check("eq held", int'(equal), 1);

        // Mismatch in slice 0: one compare cycle
        start_op(8'hA5, 8'hA4);
        lat = 0; wait_done(lat);
        check("s0 latency", lat, 1);
        check("s0 equal", int'(equal), 0);
        check("s0 diff", int'(diff_slice), 0);
        tick();

        // Mismatch only in top slice
        start_op(8'h35, 8'hB5);
        lat = 0; wait_done(lat);
        check("s3 latency", lat, 4);
        check("s3 equal", int'(equal), 0);
        check("s3 diff", int'(diff_slice), 3);
        tick();

        // Second start while busy is ignored
        start_op(8'h3C, 8'h3C);
        tick();
        a = 8'h00; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 2; wait_done(lat);
        check("ign latency", lat, 4);
        check("ign equal", int'(equal), 1);
        check("ign diff", int'(diff_slice), 0);
        tick(); tick();
        check("ign no restart", int'(busy), 0);

        // Abort at idx=2
        start_op(8'hFF, 8'hFF);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort equal", int'(equal), 0);
        start_op(8'h00, 8'h00);
        lat = 0; wait_done(lat);
        check("post-abort latency", lat, 4);
        check("post-abort equal", int'(equal), 1);
        tick();

        // Asynchronous reset in the middle of a compare
        start_op(8'h5A, 8'h5A);
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst busy", int'(busy), 0);
        check("arst done", int'(done), 0);
        check("arst equal", int'(equal), 0);
        check("arst diff", int'(diff_slice), 0);
        tick();
        rst = 1'b0;
        tick();
        start_op(8'h0F, 8'h1F);
        lat = 0; wait_done(lat);
        check("rst2 latency", lat, 3);
        check("rst2 equal", int'(equal), 0);
        check("rst2 diff", int'(diff_slice), 2);
        tick();

        // Randomized traffic, biased so many operands share low slices
        for (int i = 0; i < 2000; i++) begin
            a     = 8'($urandom);
            b     = a;
            if ($urandom_range(0, 2) != 0)
                b[2 * $urandom_range(0, 3) +: 2] = 2'($urandom);
            start = ($urandom_range(0, 2) == 0);
            abort = ($urandom_range(0, 9) == 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
